debug_module_sysid_arbiter: RTL and testbench
=============================================

// Module: debug_module_sysid_arbiter
// PURPOSE
// - Shares the single-word-pair system-ID slave (1-bit address, 32-bit combinational readdata) among NUM_REQ Avalon-MM read masters.
// - Masters are the debug bridge, the Nios boot check and the cache-switch context-save logic.
// - Grants one read per cycle: round-robin (or fixed priority) with waitrequest back-pressure; readdata returned registered with readdatavalid.
// - Sits between the requesters and debug_module_sysid in the debug_module system.
// PARAMETERS
// - NUM_REQ    2   number of requesting masters (2..8)
// - FIXED_PRIO 0   0: round-robin; 1: fixed priority, requester 0 highest
// PORTS
// - clock              in   1          system clock; all state on rising edge
// - reset_n            in   1          asynchronous, active-low reset
// - req_read           in   NUM_REQ    per-master read strobe
// - req_address        in   NUM_REQ    per-master word address (bit i = master i)
// - req_waitrequest    out  NUM_REQ    1 = read not accepted this cycle; hold request
// - req_readdatavalid  out  NUM_REQ    one-hot; req_readdata valid for that master
// - req_readdata       out  32         shared return data bus
// - slv_address        out  1          to sysid slave address
// - slv_readdata       in   32         from sysid slave; combinational on slv_address
// BEHAVIOUR
// - Reset (async assert, sync-release use): rr_ptr=0, req_readdatavalid=0, req_readdata=0, data/valid registers cleared.
//   - Combinational waitrequest during reset = req_read (nothing accepted).
// - Grant, cycle T (combinational):
//   - pending = req_read.
//   - Winner = first set bit of pending searched from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
//   - FIXED_PRIO=1: search always starts at 0.
// - req_waitrequest[i] = req_read[i] & ~grant[i]; idle masters see 0.
// - slv_address = req_address[winner] when any grant, else 0.
// - Cycle T+1 (registered):
//   - req_readdata = slv_readdata sampled at T; req_readdatavalid = grant from T.
//   - Read latency exactly 1 after acceptance.
// - rr_ptr <= (winner+1) mod NUM_REQ on a grant; unchanged when no request.
//   - Wrap: winner NUM_REQ-1 -> ptr 0.
// - Throughput: one accepted read per cycle, back-to-back; one master holding read continuously while others request gets every NUM_REQ-th slot (RR).
// - Simultaneous: all masters request at T with ptr=0 -> grants 0,1,..,NUM_REQ-1 on consecutive cycles.
// - Master dropping read while waitrequest high (protocol violation): request silently discarded, no state kept.
// - Reset asserted mid-transaction: pending readdatavalid lost (forced 0 immediately); no replay.
// - No state machine beyond pointer plus 1-deep return register; no outstanding-read limit needed since latency is fixed.
// STRUCTURE
// - Shared package debug_module_pkg:
//   - SYSID_ADDR_ID=1'b1, SYSID_ADDR_ZERO=1'b0
//   - SYSID_VALUE=32'd1672759086
//   - function clog2 for ptr width
// - Sub-module debug_module_rr_pick: pending + ptr -> one-hot grant + binary index; combinational, reused by other debug arbiters.
// - Top: ptr register, slave mux, return register.
// TESTING
// - Single master 0 reads addr1 -> waitrequest 0 same cycle; next cycle readdatavalid=01, readdata=1672759086.
// - Master 1 reads addr0 -> readdata=0, readdatavalid=10 one cycle later; rr_ptr=0 afterwards.
// - NUM_REQ=4, all read addr1 continuously from reset -> valid order 0001,0010,0100,1000,0001; waitrequest high for losers.
// - FIXED_PRIO=1, masters 0 and 2 hold read -> master 0 granted every cycle; master 2 waitrequest stays 1.
// - Masters 0 (addr0) and 1 (addr1) back-to-back -> readdata 0 then 1672759086 on consecutive cycles, no bubble.
// - Assert reset_n=0 the cycle after a grant -> readdatavalid 0 immediately, rr_ptr 0; first post-reset grant goes to lowest requester.

Source files
------------

// File: rtl/debug_module_pkg.sv
// Shared constants and helpers for the debug_module system-ID path.
package debug_module_pkg;

  // Word addresses of the system-ID slave.
  localparam logic SYSID_ADDR_ZERO = 1'b0;
  localparam logic SYSID_ADDR_ID   = 1'b1;

  // Value presented by the system-ID slave at SYSID_ADDR_ID.
  localparam logic [31:0] SYSID_VALUE = 32'd1672759086;

  // Ceiling log2, used to size requester index and pointer fields.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debug_module_rr_pick.sv
// Combinational rotating-priority picker: finds the first pending requester
// at or after ptr (wrapping), or from index 0 when FIXED is set. Produces a
// one-hot grant plus the binary index of the winner.
module debug_module_rr_pick
  import debug_module_pkg::*;
#(
  parameter int N     = 2,
  parameter int FIXED = 0,
  parameter int PW    = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] index,
  output logic          any
);

  logic [PW-1:0] start_ptr;
  logic [N-1:0]  rot;
  logic [PW-1:0] offset;
  logic [PW:0]   sum;

  // Rotate pending so the search start sits at bit 0, take the lowest set
  // bit, then rotate the offset back into an absolute requester index.
  always_comb begin
    start_ptr = (FIXED != 0) ? '0 : ptr;
    rot       = N'({pending, pending} >> start_ptr);
    offset    = '0;
    any       = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        offset = PW'(j);
        any    = 1'b1;
      end
    end
    sum = {1'b0, start_ptr} + {1'b0, offset};
    if (sum >= (PW+1)'(N)) begin
      sum = sum - (PW+1)'(N);
    end
    index = sum[PW-1:0];
    grant = any ? (N'(1) << index) : '0;
  end

endmodule

// File: rtl/debug_module_sysid_arbiter.sv
// Shares the two-word system-ID slave among NUM_REQ Avalon-MM read masters.
// One read is accepted per cycle; the slave's combinational readdata is
// captured and returned with readdatavalid exactly one cycle after acceptance.
module debug_module_sysid_arbiter
  import debug_module_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_read,
  input  logic [NUM_REQ-1:0] req_address,
  output logic [NUM_REQ-1:0] req_waitrequest,
  output logic [NUM_REQ-1:0] req_readdatavalid,
  output logic [31:0]        req_readdata,
  output logic               slv_address,
  input  logic [31:0]        slv_readdata
);

  localparam int PW = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

  logic [PW-1:0]      rr_ptr_reg;
  logic [PW-1:0]      rr_ptr_next;
  logic [NUM_REQ-1:0] pick_grant;
  logic [PW-1:0]      pick_index;
  logic               pick_any;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic [31:0]        readdata_reg;
  logic [NUM_REQ-1:0] valid_reg;

  debug_module_rr_pick #(
    .N     (NUM_REQ),
    .FIXED (FIXED_PRIO),
    .PW    (PW)
  ) u_pick (
    .pending (req_read),
    .ptr     (rr_ptr_reg),
    .grant   (pick_grant),
    .index   (pick_index),
    .any     (pick_any)
  );

  // Nothing is accepted while reset is held, so every requester stalls.
  assign any_grant = pick_any & reset_n;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign grant[gi]           = pick_grant[gi] & reset_n;
      assign req_waitrequest[gi] = req_read[gi] & ~grant[gi];
    end
  endgenerate

  // Route the winner's word address to the slave; park on address 0 when idle.
  always_comb begin
    slv_address = SYSID_ADDR_ZERO;
    if (any_grant) begin
      slv_address = req_address[pick_index];
    end
  end

  // Pointer moves to the slot after the winner, wrapping at NUM_REQ-1.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (any_grant) begin
      if (pick_index == PW'(NUM_REQ - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = pick_index + PW'(1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // One-deep return register: data of the accepted read plus its owner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_reg <= '0;
      valid_reg    <= '0;
    end else begin
      valid_reg <= grant;
      if (any_grant) begin
        readdata_reg <= slv_readdata;
      end
    end
  end

  assign req_readdata      = readdata_reg;
  assign req_readdatavalid = valid_reg;

endmodule

// File: tb/tb_debug_module_sysid_arbiter.sv
// Directed bench for debug_module_sysid_arbiter: a 2-master round-robin
// instance, a 4-master round-robin instance and a 3-master fixed-priority
// instance, each reading from a behavioural system-ID slave.
module tb_debug_module_sysid_arbiter;

  localparam logic [31:0] VAL = 32'd1672759086;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: NUM_REQ=2, round-robin
  logic [1:0]  a_read = '0, a_addr = '0, a_wait, a_valid;
  logic [31:0] a_data, a_sdata;
  logic        a_saddr;
  assign a_sdata = a_saddr ? VAL : 32'd0;

  debug_module_sysid_arbiter #(.NUM_REQ(2), .FIXED_PRIO(0)) dut_a (
    .clock(clk), .reset_n(rst_n), .req_read(a_read), .req_address(a_addr),
    .req_waitrequest(a_wait), .req_readdatavalid(a_valid), .req_readdata(a_data),
    .slv_address(a_saddr), .slv_readdata(a_sdata)
  );

  // Instance B: NUM_REQ=4, round-robin
  logic [3:0]  b_read = '0, b_addr = '0, b_wait, b_valid;
  logic [31:0] b_data, b_sdata;
  logic        b_saddr;
  assign b_sdata = b_saddr ? VAL : 32'd0;

  debug_module_sysid_arbiter #(.NUM_REQ(4), .FIXED_PRIO(0)) dut_b (
    .clock(clk), .reset_n(rst_n), .req_read(b_read), .req_address(b_addr),
    .req_waitrequest(b_wait), .req_readdatavalid(b_valid), .req_readdata(b_data),
    .slv_address(b_saddr), .slv_readdata(b_sdata)
  );

  // Instance C: NUM_REQ=3, fixed priority
  logic [2:0]  c_read = '0, c_addr = '0, c_wait, c_valid;
  logic [31:0] c_data, c_sdata;
  logic        c_saddr;
  assign c_sdata = c_saddr ? VAL : 32'd0;

  debug_module_sysid_arbiter #(.NUM_REQ(3), .FIXED_PRIO(1)) dut_c (
    .clock(clk), .reset_n(rst_n), .req_read(c_read), .req_address(c_addr),
    .req_waitrequest(c_wait), .req_readdatavalid(c_valid), .req_readdata(c_data),
    .slv_address(c_saddr), .slv_readdata(c_sdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    a_read = 2'b11;
    a_addr = 2'b11;
    repeat (2) step();
    checks++;
    if (a_wait !== 2'b11) begin errors++; $display("FAIL reset_wait got %b want %b", a_wait, 2'b11); end
    checks++;
    if (a_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want %b", a_valid, 2'b00); end
    checks++;
    if (a_data !== 32'd0) begin errors++; $display("FAIL reset_data got %0d want 0", a_data); end
    $display("reset: wait=%b valid=%b data=%0d", a_wait, a_valid, a_data);
    a_read = 2'b00;
    a_addr = 2'b00;
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_m0();
    a_read = 2'b01;
    a_addr = 2'b01;
    #1;
    checks++;
    if (a_wait !== 2'b00) begin errors++; $display("FAIL m0_wait got %b want %b", a_wait, 2'b00); end
    checks++;
    if (a_saddr !== 1'b1) begin errors++; $display("FAIL m0_saddr got %b want 1", a_saddr); end
    step();
    a_read = 2'b00;
    checks++;
    if (a_valid !== 2'b01) begin errors++; $display("FAIL m0_valid got %b want %b", a_valid, 2'b01); end
    checks++;
    if (a_data !== VAL) begin errors++; $display("FAIL m0_data got %0d want %0d", a_data, VAL); end
    $display("m0 addr1: valid=%b data=%0d", a_valid, a_data);
    step();
    checks++;
    if (a_valid !== 2'b00) begin errors++; $display("FAIL m0_valid_drop got %b want %b", a_valid, 2'b00); end
  endtask

  task automatic test_single_m1();
    a_read = 2'b10;
    a_addr = 2'b00;
    #1;
    checks++;
    if (a_wait !== 2'b00) begin errors++; $display("FAIL m1_wait got %b want %b", a_wait, 2'b00); end
    step();
    a_read = 2'b00;
    checks++;
    if (a_valid !== 2'b10) begin errors++; $display("FAIL m1_valid got %b want %b", a_valid, 2'b10); end
    checks++;
    if (a_data !== 32'd0) begin errors++; $display("FAIL m1_data got %0d want 0", a_data); end
    $display("m1 addr0: valid=%b data=%0d", a_valid, a_data);
  endtask

  // Pointer is back at 0 after master 1 wins, so master 0 wins the tie here;
  // master 1 then follows in the very next cycle.
  task automatic test_back_to_back();
    a_read = 2'b11;
    a_addr = 2'b10;
    #1;
    checks++;
    if (a_wait !== 2'b10) begin errors++; $display("FAIL b2b_wait0 got %b want %b", a_wait, 2'b10); end
    checks++;
    if (a_saddr !== 1'b0) begin errors++; $display("FAIL b2b_saddr0 got %b want 0", a_saddr); end
    step();
    a_read = 2'b10;
    #1;
    checks++;
    if (a_valid !== 2'b01 || a_data !== 32'd0) begin
      errors++; $display("FAIL b2b_first got valid=%b data=%0d want valid=01 data=0", a_valid, a_data);
    end
    checks++;
    if (a_wait !== 2'b00) begin errors++; $display("FAIL b2b_wait1 got %b want %b", a_wait, 2'b00); end
    $display("b2b first: valid=%b data=%0d", a_valid, a_data);
    step();
    a_read = 2'b00;
    checks++;
    if (a_valid !== 2'b10 || a_data !== VAL) begin
      errors++; $display("FAIL b2b_second got valid=%b data=%0d want valid=10 data=%0d", a_valid, a_data, VAL);
    end
    $display("b2b second: valid=%b data=%0d", a_valid, a_data);
    step();
  endtask

  task automatic test_rr4();
    logic [3:0] exp_valid [5];
    logic [3:0] exp_wait  [5];
    exp_valid = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_wait  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    b_read = 4'b1111;
    b_addr = 4'b1111;
    #1;
    checks++;
    if (b_wait !== 4'b1110) begin errors++; $display("FAIL rr4_wait_init got %b want %b", b_wait, 4'b1110); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (b_valid !== exp_valid[k] || b_data !== VAL) begin
        errors++; $display("FAIL rr4_valid[%0d] got %b/%0d want %b/%0d", k, b_valid, b_data, exp_valid[k], VAL);
      end
      checks++;
      if (b_wait !== exp_wait[k]) begin
        errors++; $display("FAIL rr4_wait[%0d] got %b want %b", k, b_wait, exp_wait[k]);
      end
      $display("rr4 cycle %0d: valid=%b wait=%b", k, b_valid, b_wait);
    end
    b_read = 4'b0000;
    step();
  endtask

  task automatic test_fixed();
    c_read = 3'b101;
    c_addr = 3'b111;
    #1;
    checks++;
    if (c_wait !== 3'b100) begin errors++; $display("FAIL fixed_wait_init got %b want %b", c_wait, 3'b100); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (c_valid !== 3'b001 || c_wait !== 3'b100) begin
        errors++; $display("FAIL fixed[%0d] got valid=%b wait=%b want valid=001 wait=100", k, c_valid, c_wait);
      end
      $display("fixed cycle %0d: valid=%b wait=%b", k, c_valid, c_wait);
    end
    c_read = 3'b000;
    step();
  endtask

  // Master 0 wins (pointer -> 1), then reset lands while its data is returning.
  task automatic test_reset_mid();
    a_read = 2'b01;
    a_addr = 2'b00;
    step();
    a_read = 2'b00;
    checks++;
    if (a_valid !== 2'b01) begin errors++; $display("FAIL mid_pre_valid got %b want %b", a_valid, 2'b01); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_valid !== 2'b00) begin errors++; $display("FAIL mid_valid got %b want %b", a_valid, 2'b00); end
    $display("reset mid: valid=%b", a_valid);
    step();
    #1;
    rst_n  = 1'b1;
    a_read = 2'b11;
    #1;
    checks++;
    if (a_wait !== 2'b10) begin errors++; $display("FAIL post_reset_wait got %b want %b", a_wait, 2'b10); end
    step();
    a_read = 2'b00;
    checks++;
    if (a_valid !== 2'b01) begin errors++; $display("FAIL post_reset_valid got %b want %b", a_valid, 2'b01); end
    $display("post reset: valid=%b", a_valid);
    step();
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_single_m1();
    test_back_to_back();
    test_rr4();
    test_fixed();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
